// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, selects next-PC (jump > taken branch > PC+4)
// and paces fetch with a BOOT/RUN/HALT FSM. Optional PC_RETIRE_CNT_EN adds retire_cnt_o.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_ack_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] imm_sl2_i,
  input  logic            jump_i,
  input  logic [25:0]     jaddr_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            fetch_req_o,
  output logic            halted_o
`ifdef PC_RETIRE_CNT_EN
  , output logic [31:0]   retire_cnt_o
`endif
);

  localparam logic [PC_W-1:0] PC_STEP   = {{(PC_W-3){1'b0}}, 3'b100};
  localparam logic [PC_W-1:0] ALIGN_MSK = {{(PC_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] next_pc_s;
  logic            req_r;
  logic            halted_r;
  logic            accept_s;

  assign pc_o        = pc_r;
  assign pc_plus4_o  = pc_r + PC_STEP;
  assign fetch_req_o = req_r;
  assign halted_o    = halted_r;
  assign accept_s    = (state_r == ST_RUN) && fetch_ack_i;

  // Next-PC select; the low offset bits are masked so the PC stays word-aligned
  always_comb begin
    next_pc_s = pc_plus4_o;
    if (jump_i) begin
      next_pc_s = {pc_plus4_o[PC_W-1:28], jaddr_i, 2'b00};
    end else if (branch_i && zero_i) begin
      next_pc_s = pc_plus4_o + (imm_sl2_i & ALIGN_MSK);
    end else begin
      next_pc_s = pc_plus4_o;
    end
  end

  // Run/halt FSM with PC register; req/halted are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC;
      req_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r  <= ST_RUN;
          req_r    <= 1'b1;
          halted_r <= 1'b0;
        end
        ST_RUN: begin
          if (fetch_ack_i) begin
            pc_r <= next_pc_s;
          end else begin
            pc_r <= pc_r;
          end
          if (halt_i) begin
            state_r  <= ST_HALT;
            req_r    <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            req_r    <= 1'b1;
            halted_r <= 1'b0;
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          req_r    <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_BOOT;
          pc_r     <= RESET_PC;
          req_r    <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;
  assign retire_cnt_o = retire_cnt_r;

  // Accepted-fetch counter, wraps naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_r <= 32'd0;
    end else if (accept_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

endmodule
